// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared constants, state type and word-count helper for the DMA read master
// Contents: RM_* state encodings, DMA_WORD_BYTES, DMA_BE_FULL, rm_state_t, words_of().
package dma_pkg;

  localparam logic [1:0] RM_IDLE  = 2'd0;
  localparam logic [1:0] RM_ISSUE = 2'd1;
  localparam logic [1:0] RM_DRAIN = 2'd2;

  localparam int         DMA_WORD_BYTES = 4;
  localparam logic [3:0] DMA_BE_FULL    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = RM_IDLE,
    ST_ISSUE = RM_ISSUE,
    ST_DRAIN = RM_DRAIN
  } rm_state_t;

  // Byte length rounded up to whole 32-bit words; a 33-bit sum keeps the
  // carry so Length near 2^32 does not wrap to a tiny count.
  function automatic logic [30:0] words_of(input logic [31:0] len);
    logic [32:0] sum;
    sum = {1'b0, len} + 33'd3;
    return sum[32:2];
  endfunction

endpackage

// File: rtl/dma_read_master_if.sv
// rtl/dma_read_master_if.sv - Avalon-MM pipelined read bus between the read master and memory
// Signals: oRM_read, oRM_readaddress[31:0], oRM_byteenable[3:0] (master -> slave);
//          iRM_waitrequest, iRM_readdata[31:0], iRM_readdatavalid (slave -> master).
// Modports: master (read master side), slave (memory / bench side).
interface dma_read_master_if;

  logic        oRM_read;
  logic [31:0] oRM_readaddress;
  logic [3:0]  oRM_byteenable;
  logic        iRM_waitrequest;
  logic [31:0] iRM_readdata;
  logic        iRM_readdatavalid;

  modport master (
    output oRM_read, oRM_readaddress, oRM_byteenable,
    input  iRM_waitrequest, iRM_readdata, iRM_readdatavalid
  );

  modport slave (
    input  oRM_read, oRM_readaddress, oRM_byteenable,
    output iRM_waitrequest, iRM_readdata, iRM_readdatavalid
  );

endinterface

// File: rtl/dma_rm_credit.sv
// rtl/dma_rm_credit.sv - pending-read counter and FIFO space check for the DMA read master
// Ports: iClk, iReset (sync, active-high); accept (read accepted on the bus);
//        ret (a returned word leaves the FF_write register into the FIFO);
//        FF_usedw[FIFO_AW:0] (FIFO fill); may_issue (room for one more read).
module dma_rm_credit #(
  parameter int MAX_PENDING = 4,
  parameter int FIFO_DEPTH  = 256,
  parameter int FIFO_AW     = 8
) (
  input  logic               iClk,
  input  logic               iReset,
  input  logic               accept,
  input  logic               ret,
  input  logic [FIFO_AW:0]   FF_usedw,
  output logic               may_issue
);

  // Up to 15 reads in flight. A word stays counted while it sits in the
  // FF_write register, so the moment it leaves here it shows up in FF_usedw
  // and the sum below never dips below the true commitment to the FIFO.
  logic [3:0]  pending;
  logic [31:0] fill;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      pending <= 4'd0;
    end else if (accept && !ret) begin
      pending <= pending + 4'd1;
    end else if (!accept && ret) begin
      pending <= pending - 4'd1;
    end
  end

  assign fill      = 32'(FF_usedw) + 32'(pending);
  assign may_issue = (32'(pending) < 32'(MAX_PENDING)) && (fill < 32'(FIFO_DEPTH));

endmodule

// File: rtl/dma_read_master.sv
// rtl/dma_read_master.sv - Avalon-MM pipelined read master feeding the DMA FIFO
// Ports: iClk, iReset (sync, active-high); Start, Length[31:0], RM_startaddress[31:0]
//        from the control slave; FF_usedw[FIFO_AW:0] in, FF_write/FF_data[31:0] out
//        to the FIFO; avm (dma_read_master_if.master) Avalon read bus; RM_done level.
// Optional: DMA_READ_MASTER_PERF_EN adds RM_stall_cycles[31:0] (waitrequest stall count).
module dma_read_master
  import dma_pkg::*;
#(
  parameter int MAX_PENDING = 4,
  parameter int FIFO_DEPTH  = 256,
  parameter int FIFO_AW     = 8
) (
  input  logic                iClk,
  input  logic                iReset,
  input  logic                Start,
  input  logic [31:0]         Length,
  input  logic [31:0]         RM_startaddress,
  input  logic [FIFO_AW:0]    FF_usedw,
  output logic                FF_write,
  output logic [31:0]         FF_data,
  dma_read_master_if.master   avm,
  output logic                RM_done
`ifdef DMA_READ_MASTER_PERF_EN
  ,
  output logic [31:0]         RM_stall_cycles
`endif
);

  rm_state_t   state_q, state_d;
  logic [30:0] issue_cnt, recv_cnt;
  logic [31:0] addr_q;
  logic        hold_q;
  logic        may_issue;
  logic        start_ok, rd, accept, ret_valid;

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    rd       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_ok = Start && (Length != 32'd0);
        if (start_ok) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // hold_q keeps a stalled request up even if credit changes meanwhile.
        rd = hold_q || ((issue_cnt != 31'd0) && may_issue);
        if (rd && !avm.iRM_waitrequest && (issue_cnt == 31'd1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (recv_cnt == 31'd0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept    = rd && !avm.iRM_waitrequest;
  // Data arriving while idle or after all words are in is stale (e.g. left
  // over from a reset mid-transfer) and is dropped.
  assign ret_valid = avm.iRM_readdatavalid && (state_q != ST_IDLE) && (recv_cnt != 31'd0);

  assign avm.oRM_read        = rd;
  assign avm.oRM_readaddress = addr_q;
  assign avm.oRM_byteenable  = rd ? DMA_BE_FULL : 4'b0000;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q   <= ST_IDLE;
      issue_cnt <= 31'd0;
      recv_cnt  <= 31'd0;
      addr_q    <= 32'd0;
      hold_q    <= 1'b0;
      FF_write  <= 1'b0;
      FF_data   <= 32'd0;
      RM_done   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= rd && avm.iRM_waitrequest;
      FF_write <= ret_valid;
      if (ret_valid) begin
        FF_data  <= avm.iRM_readdata;
        recv_cnt <= recv_cnt - 31'd1;
      end
      if (accept) begin
        issue_cnt <= issue_cnt - 31'd1;
        addr_q    <= addr_q + 32'(DMA_WORD_BYTES);
      end
      if (start_ok) begin
        addr_q    <= RM_startaddress & ~32'h3;
        issue_cnt <= words_of(Length);
        recv_cnt  <= words_of(Length);
        RM_done   <= 1'b0;
      end
      if ((state_q == ST_DRAIN) && (recv_cnt == 31'd0)) RM_done <= 1'b1;
    end
  end

  dma_rm_credit #(
    .MAX_PENDING (MAX_PENDING),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .FIFO_AW     (FIFO_AW)
  ) u_credit (
    .iClk      (iClk),
    .iReset    (iReset),
    .accept    (accept),
    .ret       (FF_write),
    .FF_usedw  (FF_usedw),
    .may_issue (may_issue)
  );

`ifdef DMA_READ_MASTER_PERF_EN
  always_ff @(posedge iClk) begin
    if (iReset || start_ok) begin
      RM_stall_cycles <= 32'd0;
    end else if (rd && avm.iRM_waitrequest && (RM_stall_cycles != 32'hFFFF_FFFF)) begin
      RM_stall_cycles <= RM_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
